riscv_multicycle_datapath: RTL



---
 rtl/rv_mc_pkg.sv | 22 ++
 rtl/rv_mc_control.sv | 105 ++++++++++
 rtl/riscv_multicycle_datapath.sv | 77 +++++++
 3 files changed

// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg: shared FSM states, opcodes, ALU and immediate-select codes
package rv_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/rv_mc_control.sv
// rv_mc_control: multicycle main FSM and ALU decoder driving all datapath enables and selects
module rv_mc_control
  import rv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output state_t     state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       retire,
  output logic       trap,
  output logic       ir_we,
  output logic       data_we,
  output logic       ab_we,
  output logic       aluout_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       adr_src,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] imm_src,
  output logic [1:0] pc_src,
  output logic [1:0] wb_src,
  output logic [2:0] alu_op
);
  logic fire, store, ex;
  logic [2:0] f_op;
  state_t dec;
  assign fire  = mem_req && mem_ready;
  assign store = op == OP_STORE;
  assign ex    = state == S_EXECR || state == S_EXECI;
  assign dec = (op == OP_LOAD || store) ? S_MEMADR :
               op == OP_R   ? S_EXECR :
               op == OP_I   ? S_EXECI :
               op == OP_BEQ ? S_BEQ   :
               op == OP_JAL ? S_JAL   : S_TRAP;
  assign f_op = funct3 == 3'b000 ? ((state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD) :
                funct3 == 3'b010 ? ALU_SLT :
                funct3 == 3'b110 ? ALU_OR  :
                funct3 == 3'b111 ? ALU_AND : ALU_ADD;
  assign alu_op    = ex ? f_op : state == S_BEQ ? ALU_SUB : ALU_ADD;
  assign ir_we     = state == S_FETCH && fire;
  assign data_we   = state == S_MEMREAD && fire;
  assign ab_we     = state == S_DECODE;
  assign aluout_we = state == S_DECODE || state == S_MEMADR || ex;
  assign pc_we     = ir_we || (state == S_BEQ && zero) || state == S_JAL;
  assign pc_src    = state == S_BEQ ? 2'd1 : state == S_JAL ? 2'd2 : 2'd0;
  assign reg_we    = state == S_MEMWB || state == S_ALUWB || state == S_JAL;
  assign wb_src    = state == S_MEMWB ? 2'd1 : state == S_JAL ? 2'd2 : 2'd0;
  assign adr_src   = state == S_MEMREAD || state == S_MEMWRITE;
  assign a_sel     = state == S_DECODE || state == S_JAL;
  assign b_sel     = state == S_DECODE || state == S_MEMADR || state == S_EXECI || state == S_JAL;
  assign imm_src   = state == S_DECODE ? IMM_B : state == S_JAL ? IMM_J :
                     (state == S_MEMADR && store) ? IMM_S : IMM_I;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      retire  <= 1'b0;
      trap    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          mem_req <= !fire;
          if (fire) state <= S_DECODE;
        end
        S_DECODE: begin
          state <= dec;
          trap  <= dec == S_TRAP;
        end
        S_MEMADR: begin
          state   <= store ? S_MEMWRITE : S_MEMREAD;
          mem_req <= 1'b1;
          mem_we  <= store;
        end
        S_MEMREAD: if (fire) begin
          state   <= S_MEMWB;
          mem_req <= 1'b0;
        end
        S_MEMWRITE: if (fire) begin
          state  <= S_FETCH;
          mem_we <= 1'b0;
          retire <= 1'b1;
        end
        S_EXECR, S_EXECI: state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BEQ, S_JAL: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
          retire  <= 1'b1;
        end
        default: begin
          state <= S_TRAP;
          trap  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/riscv_multicycle_datapath.sv
// riscv_multicycle_datapath: multicycle RV32I-subset core with unified handshaked memory port
module riscv_multicycle_datapath
  import rv_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [31:0]       pc_out,
  output logic              trap
);
  state_t state;
  logic ir_we, data_we, ab_we, aluout_we, pc_we, reg_we, adr_src, a_sel, b_sel;
  logic [1:0] imm_src, pc_src, wb_src;
  logic [2:0] alu_op;
  logic [31:0] pc, old_pc, ir, data, a, b, alu_out;
  logic [31:0] rf [32];
  logic [31:0] imm, src_a, src_b, alu_res, wb, pc_next, addr;
  rv_mc_control u_ctrl (
    .clk(clk), .rst(rst), .op(ir[6:0]), .funct3(ir[14:12]), .funct7b5(ir[30]),
    .zero(alu_res == 32'd0), .mem_ready(mem_ready), .state(state),
    .mem_req(mem_req), .mem_we(mem_we), .retire(retire), .trap(trap),
    .ir_we(ir_we), .data_we(data_we), .ab_we(ab_we), .aluout_we(aluout_we),
    .pc_we(pc_we), .reg_we(reg_we), .adr_src(adr_src), .a_sel(a_sel), .b_sel(b_sel),
    .imm_src(imm_src), .pc_src(pc_src), .wb_src(wb_src), .alu_op(alu_op)
  );
  assign imm = imm_src == IMM_I ? {{20{ir[31]}}, ir[31:20]} :
               imm_src == IMM_S ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
               imm_src == IMM_B ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0} :
                                  {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  assign src_a = a_sel ? old_pc : a;
  assign src_b = b_sel ? imm : b;
  assign alu_res = alu_op == ALU_SUB ? src_a - src_b :
                   alu_op == ALU_AND ? src_a & src_b :
                   alu_op == ALU_OR  ? src_a | src_b :
                   alu_op == ALU_SLT ? {31'd0, $signed(src_a) < $signed(src_b)} :
                                       src_a + src_b;
  assign wb        = wb_src == 2'd1 ? data : wb_src == 2'd2 ? pc : alu_out;
  assign pc_next   = pc_src == 2'd1 ? alu_out : pc_src == 2'd2 ? alu_res : pc + 32'd4;
  assign addr      = (adr_src ? alu_out : pc) & ~32'd3;
  assign mem_addr  = addr[ADDR_W-1:0];
  assign mem_wdata = b;
  assign pc_out    = state == S_FETCH ? pc : old_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= '0;
      data    <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (ir_we) begin
        ir     <= mem_rdata;
        old_pc <= pc;
      end
      if (pc_we) pc <= pc_next;
      if (data_we) data <= mem_rdata;
      if (ab_we) begin
        a <= rf[ir[19:15]];
        b <= rf[ir[24:20]];
      end
      if (aluout_we) alu_out <= alu_res;
      if (reg_we && ir[11:7] != 5'd0) rf[ir[11:7]] <= wb;
    end
  end
endmodule
